// File: rtl/edge_filter_ctrl.sv
// rtl/edge_filter_ctrl.sv - frame sequencer: pixel coordinates, kernel-mode latch, border tags, frame checks
module edge_filter_ctrl #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int FCNT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        mode_req,
  input  logic              valid_in,
  input  logic              ready_in,
  input  logic              sop_in,
  input  logic              eop_in,
  output logic [2:0]        freq_flag,
  output logic              mode_pending,
  output logic              frame_active,
  output logic              tag_valid,
  output logic [8:0]        x_pos,
  output logic [7:0]        y_pos,
  output logic              border_mask,
  output logic              frame_done,
  output logic              frame_err,
  output logic [FCNT_W-1:0] frame_count
);

  localparam logic [8:0] X_LAST = 9'(IMG_W - 1);
  localparam logic [7:0] Y_LAST = 8'(IMG_H - 1);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [8:0]        x_cnt_q, x_cnt_d;
  logic [7:0]        y_cnt_q, y_cnt_d;
  logic [2:0]        freq_q, freq_d;
  logic              pend_q, pend_d;
  logic              tag_q, tag_d;
  logic [8:0]        x_pos_q, x_pos_d;
  logic [7:0]        y_pos_q, y_pos_d;
  logic              border_q, border_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [FCNT_W-1:0] count_q, count_d;

  logic              accept;
  logic [2:0]        mode_coerced;
  logic              at_last;
  logic [8:0]        tag_x;
  logic [7:0]        tag_y;

  // True when (x,y) lies within radius r of any image edge; r=0 never matches.
  function automatic logic border_of(input logic [8:0] x, input logic [7:0] y,
                                     input logic [1:0] r);
    logic lo_x, hi_x, lo_y, hi_y;
    lo_x = x < {7'd0, r};
    hi_x = (10'(x) + 10'(r)) > 10'(IMG_W - 1);
    lo_y = y < {6'd0, r};
    hi_y = (9'(y) + 9'(r)) > 9'(IMG_H - 1);
    return lo_x | hi_x | lo_y | hi_y;
  endfunction

  // Beat qualification, illegal-mode coercion and last-pixel detection.
  always_comb begin
    accept       = valid_in & ready_in;
    mode_coerced = (mode_req > 3'd2) ? 3'd0 : mode_req;
    at_last      = (x_cnt_q == X_LAST) && (y_cnt_q == Y_LAST);
  end

  // Next-state logic: frame sequencing, coordinate tagging and pulse generation.
  always_comb begin
    state_d  = state_q;
    x_cnt_d  = x_cnt_q;
    y_cnt_d  = y_cnt_q;
    freq_d   = freq_q;
    tag_d    = 1'b0;
    tag_x    = 9'd0;
    tag_y    = 8'd0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    count_d  = count_q;

    if (accept) begin
      if (sop_in) begin
        // Any SOP restarts the frame; an SOP inside a frame or an SOP+EOP beat is malformed.
        err_d   = (state_q == S_ACTIVE) | eop_in;
        freq_d  = mode_coerced;
        tag_d   = 1'b1;
        x_cnt_d = 9'd1;
        y_cnt_d = 8'd0;
        state_d = eop_in ? S_IDLE : S_ACTIVE;
      end else if (state_q == S_ACTIVE) begin
        tag_d = 1'b1;
        tag_x = x_cnt_q;
        tag_y = y_cnt_q;
        if (eop_in) begin
          done_d  = at_last;
          err_d   = ~at_last;
          count_d = at_last ? count_q + FCNT_W'(1) : count_q;
          state_d = S_IDLE;
        end else if (at_last) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (x_cnt_q == X_LAST) begin
          x_cnt_d = 9'd0;
          y_cnt_d = y_cnt_q + 8'd1;
        end else begin
          x_cnt_d = x_cnt_q + 9'd1;
        end
      end
    end

    // Tag fields hold between beats; border uses the mode as updated by this beat.
    x_pos_d  = tag_d ? tag_x : x_pos_q;
    y_pos_d  = tag_d ? tag_y : y_pos_q;
    border_d = tag_d ? border_of(tag_x, tag_y, freq_d[1:0]) : border_q;
    pend_d   = mode_coerced != freq_d;
  end

  // State register and registered outputs, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      x_cnt_q  <= 9'd0;
      y_cnt_q  <= 8'd0;
      freq_q   <= 3'd0;
      pend_q   <= 1'b0;
      tag_q    <= 1'b0;
      x_pos_q  <= 9'd0;
      y_pos_q  <= 8'd0;
      border_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      x_cnt_q  <= x_cnt_d;
      y_cnt_q  <= y_cnt_d;
      freq_q   <= freq_d;
      pend_q   <= pend_d;
      tag_q    <= tag_d;
      x_pos_q  <= x_pos_d;
      y_pos_q  <= y_pos_d;
      border_q <= border_d;
      done_q   <= done_d;
      err_q    <= err_d;
      count_q  <= count_d;
    end
  end

  // Output mapping straight from flops.
  always_comb begin
    freq_flag    = freq_q;
    mode_pending = pend_q;
    frame_active = (state_q == S_ACTIVE);
    tag_valid    = tag_q;
    x_pos        = x_pos_q;
    y_pos        = y_pos_q;
    border_mask  = border_q;
    frame_done   = done_q;
    frame_err    = err_q;
    frame_count  = count_q;
  end

endmodule

// File: tb/tb_edge_filter_ctrl.sv
// tb/tb_edge_filter_ctrl.sv - randomized and directed bench for edge_filter_ctrl with a beat-index reference model
module tb_edge_filter_ctrl;

  localparam int W = 320;
  localparam int H = 240;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  mode_req;
  logic        valid_in, ready_in, sop_in, eop_in;
  logic [2:0]  freq_flag;
  logic        mode_pending, frame_active, tag_valid, border_mask, frame_done, frame_err;
  logic [8:0]  x_pos;
  logic [7:0]  y_pos;
  logic [15:0] frame_count;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state: frame progress is a flat beat index
  int m_active, m_idx, m_freq, m_count;
  int exp_pend, exp_tag, exp_x, exp_y, exp_border, exp_done, exp_err;

  edge_filter_ctrl #(.IMG_W(W), .IMG_H(H), .FCNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .mode_req(mode_req),
    .valid_in(valid_in), .ready_in(ready_in), .sop_in(sop_in), .eop_in(eop_in),
    .freq_flag(freq_flag), .mode_pending(mode_pending), .frame_active(frame_active),
    .tag_valid(tag_valid), .x_pos(x_pos), .y_pos(y_pos), .border_mask(border_mask),
    .frame_done(frame_done), .frame_err(frame_err), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  wire [41:0] obs_vec = {freq_flag, mode_pending, frame_active, tag_valid, x_pos, y_pos,
                         border_mask, frame_done, frame_err, frame_count};

  function automatic logic [41:0] exp_vec();
    return {3'(m_freq), 1'(exp_pend), 1'(m_active), 1'(exp_tag), 9'(exp_x), 8'(exp_y),
            1'(exp_border), 1'(exp_done), 1'(exp_err), 16'(m_count)};
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    int m, r;
    m = (mode_req > 2) ? 0 : int'(mode_req);
    exp_tag = 0; exp_done = 0; exp_err = 0;
    if (!reset_n) begin
      m_active = 0; m_idx = 0; m_freq = 0; m_count = 0;
      exp_x = 0; exp_y = 0; exp_border = 0; exp_pend = 0;
      return;
    end
    if (valid_in && ready_in) begin
      if (sop_in) begin
        exp_err  = (m_active != 0 || eop_in) ? 1 : 0;
        m_freq   = m;
        exp_tag  = 1; exp_x = 0; exp_y = 0;
        m_active = eop_in ? 0 : 1;
        m_idx    = 1;
      end else if (m_active != 0) begin
        exp_tag = 1;
        exp_x   = m_idx % W;
        exp_y   = m_idx / W;
        if (eop_in || m_idx == W * H - 1) begin
          if (eop_in && m_idx == W * H - 1) begin
            exp_done = 1;
            m_count  = (m_count + 1) % 65536;
          end else begin
            exp_err = 1;
          end
          m_active = 0;
        end else begin
          m_idx++;
        end
      end
    end
    if (exp_tag != 0) begin
      r = m_freq;
      exp_border = (exp_x < r || exp_x > W - 1 - r || exp_y < r || exp_y > H - 1 - r) ? 1 : 0;
    end
    exp_pend = (m != m_freq) ? 1 : 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic s, input logic e);
    valid_in = 1'b1; ready_in = 1'b1; sop_in = s; eop_in = e;
    tick();
  endtask

  task automatic idle_cycle();
    valid_in = 1'b0; ready_in = 1'b0; sop_in = 1'b0; eop_in = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mode_req = 3'd1;
    valid_in = 1'b1; ready_in = 1'b1; sop_in = 1'b1; eop_in = 1'b0;
    tick();
    tick();
    n_tests++;
    if (freq_flag !== 3'd0) begin n_fail++; $display("FAIL reset_freq_flag got %0d want 0", freq_flag); end
    n_tests++;
    if (frame_active !== 1'b0 || tag_valid !== 1'b0 || mode_pending !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags got act=%b tag=%b pend=%b want 0", frame_active, tag_valid, mode_pending);
    end
    n_tests++;
    if (frame_count !== 16'd0 || frame_done !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_count got cnt=%0d done=%b err=%b want 0", frame_count, frame_done, frame_err);
    end
    reset_n = 1'b1;
    idle_cycle();
  endtask

  // Clean full frame in 3x3 mode; late in the frame mode_req moves to 2.
  task automatic test_full_frame();
    int done_seen;
    done_seen = 0;
    mode_req = 3'd1;
    for (int i = 0; i < W * H; i++) begin
      if (i == 70000) mode_req = 3'd2;
      beat(i == 0, i == W * H - 1);
      n_tests++;
      if (obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL full_frame beat %0d got %h want %h", i, obs_vec, exp_vec());
      end
      if (frame_done === 1'b1) done_seen++;
      if (i == 0) begin
        n_tests++;
        if (freq_flag !== 3'd1) begin n_fail++; $display("FAIL full_first_freq got %0d want 1", freq_flag); end
      end
      if (i == 70000) begin
        n_tests++;
        if (freq_flag !== 3'd1 || mode_pending !== 1'b1) begin
          n_fail++; $display("FAIL mid_mode_change got freq=%0d pend=%b want freq=1 pend=1", freq_flag, mode_pending);
        end
      end
      if (i == W * H - 1) begin
        n_tests++;
        if (tag_valid !== 1'b1 || x_pos !== 9'd319 || y_pos !== 8'd239 || frame_done !== 1'b1) begin
          n_fail++; $display("FAIL last_tag got v=%b (%0d,%0d) done=%b want v=1 (319,239) done=1",
                             tag_valid, x_pos, y_pos, frame_done);
        end
      end
    end
    idle_cycle();
    n_tests++;
    if (done_seen != 1 || frame_count !== 16'd1 || frame_active !== 1'b0) begin
      n_fail++; $display("FAIL frame_complete got done_pulses=%0d cnt=%0d act=%b want 1 1 0",
                         done_seen, frame_count, frame_active);
    end
  endtask

  // 5x5 frame: pending mode applies at SOP, border points, then SOP at (100,50).
  task automatic test_kernel5_and_sop();
    int bx, by, want;
    for (int i = 0; i <= 50 * W + 100; i++) begin
      bx = i % W; by = i / W;
      if (i == 50 * W + 100) mode_req = 3'd1;
      beat(i == 0 || i == 50 * W + 100, 1'b0);
      n_tests++;
      if (obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL kernel5 beat %0d got %h want %h", i, obs_vec, exp_vec());
      end
      if (i == 0) begin
        n_tests++;
        if (freq_flag !== 3'd2 || mode_pending !== 1'b0) begin
          n_fail++; $display("FAIL sop_mode_apply got freq=%0d pend=%b want freq=2 pend=0", freq_flag, mode_pending);
        end
      end
      want = -1;
      if (bx == 1   && by == 5)  want = 1;
      if (bx == 318 && by == 40) want = 1;
      if (bx == 2   && by == 2)  want = 0;
      if (bx == 317 && by == 45) want = 0;
      if (bx == 0   && by == 1)  want = 1;
      if (want >= 0) begin
        n_tests++;
        if (border_mask !== 1'(want)) begin
          n_fail++; $display("FAIL border5 (%0d,%0d) got %b want %0d", bx, by, border_mask, want);
        end
      end
      if (i == 50 * W + 100) begin
        n_tests++;
        if (frame_err !== 1'b1 || tag_valid !== 1'b1 || x_pos !== 9'd0 || y_pos !== 8'd0 || frame_active !== 1'b1) begin
          n_fail++; $display("FAIL sop_mid got err=%b v=%b (%0d,%0d) act=%b want 1 1 (0,0) 1",
                             frame_err, tag_valid, x_pos, y_pos, frame_active);
        end
      end
    end
  endtask

  // Continues the frame restarted above; EOP at (10,3) is premature.
  task automatic test_eop_early();
    for (int i = 1; i <= 3 * W + 10; i++) begin
      beat(1'b0, i == 3 * W + 10);
      n_tests++;
      if (obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL eop_early beat %0d got %h want %h", i, obs_vec, exp_vec());
      end
    end
    n_tests++;
    if (frame_err !== 1'b1 || frame_done !== 1'b0 || frame_active !== 1'b0 || x_pos !== 9'd10 || y_pos !== 8'd3) begin
      n_fail++; $display("FAIL eop_early_err got err=%b done=%b act=%b (%0d,%0d) want 1 0 0 (10,3)",
                         frame_err, frame_done, frame_active, x_pos, y_pos);
    end
    for (int k = 0; k < 3; k++) begin
      beat(1'b0, 1'b0);
      n_tests++;
      if (tag_valid !== 1'b0 || frame_active !== 1'b0) begin
        n_fail++; $display("FAIL idle_untagged got tag=%b act=%b want 0 0", tag_valid, frame_active);
      end
    end
  endtask

  // Random valid/ready gaps with an illegal mode; reset lands mid-frame.
  task automatic test_random_gaps();
    int acc_cnt, tag_cnt;
    acc_cnt = 0; tag_cnt = 0;
    mode_req = 3'd7;
    for (int c = 0; c < 600; c++) begin
      valid_in = ($urandom_range(0, 3) != 0);
      ready_in = ($urandom_range(0, 3) != 0);
      sop_in   = (c == 0) || ($urandom_range(0, 39) == 0);
      eop_in   = ($urandom_range(0, 59) == 0);
      if (c == 0) begin valid_in = 1'b1; ready_in = 1'b1; end
      if (valid_in && ready_in && (m_active != 0 || sop_in)) acc_cnt++;
      tick();
      if (tag_valid === 1'b1) tag_cnt++;
      n_tests++;
      if (obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL random cycle %0d got %h want %h", c, obs_vec, exp_vec());
      end
    end
    n_tests++;
    if (tag_cnt != acc_cnt || freq_flag !== 3'd0) begin
      n_fail++; $display("FAIL random_totals got tags=%0d freq=%0d want tags=%0d freq=0", tag_cnt, freq_flag, acc_cnt);
    end
    mode_req = 3'd1;
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b0);
    n_tests++;
    if (frame_active !== 1'b1 || freq_flag !== 3'd1) begin
      n_fail++; $display("FAIL pre_reset got act=%b freq=%0d want 1 1", frame_active, freq_flag);
    end
    reset_n = 1'b0;
    beat(1'b0, 1'b0);
    n_tests++;
    if (obs_vec !== 42'd0) begin
      n_fail++; $display("FAIL mid_frame_reset got %h want 0", obs_vec);
    end
    reset_n = 1'b1;
    idle_cycle();
  endtask

  initial begin
    reset_n = 1'b0; mode_req = 3'd0;
    valid_in = 1'b0; ready_in = 1'b0; sop_in = 1'b0; eop_in = 1'b0;
    test_reset();
    test_full_frame();
    test_kernel5_and_sop();
    test_eop_early();
    test_random_gaps();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
